// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_type;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The request address field is sized from the package default width.
  typedef struct packed {
    logic                      we;
    logic [LSU_ADDR_WIDTH-3:0] addr;
    logic [31:0]               wdata;
    logic [3:0]                be;
  } dmem_req_type;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] store_data;
  } ex_mem_type;

  function automatic logic f3_valid(input logic [2:0] f3, input logic is_store);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword lane and extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value_o = {24'b0, byte_sel};
      F3_H:    value_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value_o = {16'b0, half_sel};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates the EX/MEM access, runs the dmem
// req/ack handshake with a timeout, and returns aligned load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = LSU_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-3:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ex_mem_type    ex_mem;
  lsu_state_type state_q;
  dmem_req_type  req_d, req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]    ld_f3_q;
  logic [1:0]    ld_off_q;
  logic          is_load_q;
  logic [31:0]   load_data_q;
  logic          load_valid_q, fault_q;
  logic          access, is_store, good_access, bad_access;
  logic [31:0]   aligned;

  assign ex_mem = '{mem_read: mem_read, mem_write: mem_write,
                    funct3: funct3, store_data: store_data};

  // A write wins over a read when both are flagged.
  assign access      = ex_mem.mem_read | ex_mem.mem_write;
  assign is_store    = ex_mem.mem_write;
  assign good_access = access & f3_valid(ex_mem.funct3, is_store)
                     & ~misaligned(ex_mem.funct3, address[1:0]);
  assign bad_access  = access & ~good_access;

  always_comb begin
    req_d.we    = is_store;
    req_d.addr  = address[ADDR_WIDTH-1:2];
    req_d.wdata = ex_mem.store_data;
    req_d.be    = 4'b1111;
    if (is_store) begin
      case (ex_mem.funct3[1:0])
        2'b00: begin
          req_d.wdata = {4{ex_mem.store_data[7:0]}};
          req_d.be    = 4'b0001 << address[1:0];
        end
        2'b01: begin
          req_d.wdata = {2{ex_mem.store_data[15:0]}};
          req_d.be    = address[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .word_i   (dmem_rdata),
    .offset_i (ld_off_q),
    .funct3_i (ld_f3_q),
    .value_o  (aligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      ld_f3_q      <= '0;
      ld_off_q     <= '0;
      is_load_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (good_access) begin
            req_q     <= req_d;
            ld_f3_q   <= ex_mem.funct3;
            ld_off_q  <= address[1:0];
            is_load_q <= ~is_store;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end else if (bad_access) begin
            fault_q <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            if (is_load_q) begin
              load_data_q  <= aligned;
              load_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            fault_q     <= 1'b1;
            load_data_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The pipeline advances out of DONE; the stale access is not re-examined.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = reset_n & ((state_q == BUSY) | ((state_q == IDLE) & good_access));
  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;
  assign dmem_be    = req_q.be;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign fault      = fault_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage data access unit. It sits between the EX/MEM pipeline register and the write-back path.
- It takes the load/store request carried in ex_mem_reg and drives a variable-latency data memory through a req/ack handshake.
- It stalls the pipeline while an access is outstanding, and returns sized, sign- or zero-extended load data to MEM/WB.
- It faults on misaligned or invalid accesses and on memory timeouts.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the data memory.
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY waiting for dmem_ack before a fault is raised.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- mem_read  in  1  EX/MEM instruction is a load.
- mem_write  in  1  EX/MEM instruction is a store.
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- address  in  ADDR_WIDTH  byte address from execute result.
- store_data  in  32  rs2 value for stores.
- stall  out  1  hold IF/ID, ID/EX and EX/MEM registers.
- load_data  out  32  extended load result, valid with load_valid.
- load_valid  out  1  one-cycle pulse, load result ready.
- fault  out  1  one-cycle pulse: misaligned, invalid funct3, or timeout.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_WIDTH-2  word address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- dmem_ack  in  1  request completed this cycle.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; timeout counter cleared.
  - All outputs 0: stall, load_data, load_valid, fault, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be.
  - A reset mid-access drops dmem_req immediately; no completion and no fault is reported afterwards.
- Access present: access = mem_read | mem_write. If both are set, the access is a store, mem_read is ignored, and no fault is raised.
- Validity check (combinational, IDLE only):
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores, means invalid.
  - Halfword with address[0]=1 is misaligned.
  - Word with address[1:0]!=0 is misaligned.
  - Invalid or misaligned accesses issue no memory request: stall stays 0, fault pulses for one cycle, state stays IDLE.
- IDLE, valid access:
  - stall=1 combinationally in the same cycle.
  - At the clock edge, register word address, byte enables, lane data, we and load type; go to BUSY.
- BUSY:
  - dmem_req=1 and stall=1 every cycle; request fields stay stable.
  - Counter increments each cycle.
  - dmem_ack=1: capture dmem_rdata into the load aligner, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop req, set fault pulse, load_data=0, go to DONE.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - load_valid=1 for loads only; load_data holds the extended value.
  - Go to IDLE unconditionally. The inputs still show the completed access and must not retrigger.
  - load_data keeps its value until the next load completes.
- Latency: minimum 3 cycles (IDLE, BUSY with same-cycle ack, DONE); stall is high for 2 cycles. Each extra wait cycle adds 1.
- Store lanes:
  - SB: wdata={4{b}}, be=1<<address[1:0].
  - SH: wdata={2{h}}, be=0011 or 1100 per address[1].
  - SW: be=1111.
  - Loads: be=1111.
- Load extraction:
  - Select the byte lane by address[1:0] and the halfword lane by address[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Counter width: $clog2(TIMEOUT_CYCLES+1). It clears on entering BUSY.

Decomposition:
- common package:
  - lsu_state_type enum {IDLE, BUSY, DONE}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - dmem_req_type struct {we, addr, wdata, be}.
  - ex_mem_type gains mem_read, mem_write, funct3, store_data fields.
- Sub-module load_align: combinational; inputs word, offset[1:0], funct3; output 32-bit extended value.

Test Plan:
- LW at 0x008, memory word 0xDEADBEEF, ack one cycle after req. Expect stall high 3 cycles, load_valid in the next cycle with load_data=0xDEADBEEF, dmem_addr=2.
- LB at 0x00B and LBU at 0x00B on word 0x80FF7F01. Expect 0xFFFFFF80, then 0x00000080.
- SH at 0x006, store_data 0x1234ABCD. Expect dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=1, load_valid stays 0.
- LW at 0x005 and LH at 0x003. Expect a one-cycle fault for each, dmem_req never rises, stall stays 0.
- TIMEOUT_CYCLES=4, no ack. Expect req high for 4 cycles, then fault pulse, load_data=0, return to IDLE; the next valid access completes normally.
- Deassert reset_n during BUSY. Expect dmem_req and stall to drop asynchronously; after release, state is IDLE with no spurious load_valid or fault.
